// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared by the execute-stage ALU and its clients, plus the
// state encoding of the shift-and-add multiply sequencer (alu_mul_seq).
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLLI = 4'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_ADD,
    MS_SHIFT,
    MS_DONE
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle 32x32 -> low-32 multiplier built from the shared
// execute-stage ALU (shift-and-add using ALU_ADD / ALU_SLLI).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous abort back to IDLE
//   start_valid/ready operand handshake (ready only in IDLE), op_a, op_b
//   res_valid/ready   product handshake (valid only in DONE), res
//   alu_req/alu_gnt   borrow the ALU; pipeline traffic wins when gnt=0
//   alu_a/b/op        operands driven to the execute-stage mux
//   alu_result        combinational ALU result for this cycle
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result
);

  mul_state_t  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [5:0]  iter_q, iter_d;

  // Next-state / datapath
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    iter_d   = iter_q;
    case (state_q)
      MS_IDLE: if (start_valid) begin
        acc_d    = '0;
        mcand_d  = op_a;
        mplier_d = op_b;
        iter_d   = '0;
        if (EARLY_EXIT && op_b == 32'd0) state_d = MS_DONE;
        else if (op_b[0])                state_d = MS_ADD;
        else                             state_d = MS_SHIFT;
      end
      MS_ADD: if (alu_gnt) begin
        acc_d   = alu_result;
        state_d = MS_SHIFT;
      end
      MS_SHIFT: if (alu_gnt) begin
        mcand_d  = alu_result;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + 6'd1;
        // Decisions look at the pre-shift multiplier: bit 1 is the next LSB.
        if ((EARLY_EXIT && mplier_q[31:1] == 31'd0) || iter_q == 6'd31)
          state_d = MS_DONE;
        else if (mplier_q[1])
          state_d = MS_ADD;
        else
          state_d = MS_SHIFT;
      end
      MS_DONE: if (res_ready) state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
    if (flush) begin
      state_d  = MS_IDLE;
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      iter_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MS_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      iter_q   <= iter_d;
    end
  end

  // Outputs decode only registered state, so alu_gnt never loops back to alu_req.
  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    res         = '0;
    alu_req     = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ALU_ADD;
    case (state_q)
      MS_IDLE: start_ready = 1'b1;
      MS_ADD: begin
        alu_req = 1'b1;
        alu_a   = acc_q;
        alu_b   = mcand_q;
        alu_op  = ALU_ADD;
      end
      MS_SHIFT: begin
        alu_req = 1'b1;
        alu_a   = mcand_q;
        alu_b   = 32'd1;
        alu_op  = ALU_SLLI;
      end
      MS_DONE: begin
        res_valid = 1'b1;
        res       = acc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: two sequencers (EARLY_EXIT=1 and =0) driven in lockstep
// from shared stimulus, each with its own behavioural ALU; results and
// latencies are compared against plain-arithmetic expectations.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, start_valid, res_ready, gnt;
  logic [31:0] op_a, op_b;

  logic        sr1, rv1, req1, sr0, rv0, req0;
  logic [31:0] res1, a1, b1, ar1, res0, a0, b0, ar0;
  logic [3:0]  op1, op0;

  int checks = 0, errors = 0;
  bit req1_seen;

  always #5 clk = ~clk;

  // Reference ALU; garbage when not granted so a stalled write is visible.
  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic g);
    if (!g) return 32'hDEAD_BEEF;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLLI: return a << b[4:0];
      default:  return 32'h0BAD_0BAD;
    endcase
  endfunction
  assign ar1 = alu_f(a1, b1, op1, gnt);
  assign ar0 = alu_f(a0, b0, op0, gnt);

  alu_mul_seq #(.EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk), .rst(rst), .flush(flush), .start_valid(start_valid), .start_ready(sr1),
    .op_a(op_a), .op_b(op_b), .res_valid(rv1), .res_ready(res_ready), .res(res1),
    .alu_req(req1), .alu_gnt(gnt), .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_result(ar1));

  alu_mul_seq #(.EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk), .rst(rst), .flush(flush), .start_valid(start_valid), .start_ready(sr0),
    .op_a(op_a), .op_b(op_b), .res_valid(rv0), .res_ready(res_ready), .res(res0),
    .alu_req(req0), .alu_gnt(gnt), .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_result(ar0));

  always @(posedge clk) if (req1) req1_seen = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(bit ee, logic [31:0] b);
    int msb = 0;
    if (!ee) return 33 + $countones(b);
    if (b == 0) return 1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return msb + 2 + $countones(b);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One operation on both DUTs. Called #1 after an edge with both in IDLE.
  // stall_at/stall_n: cycles (counted from accept) with gnt low.
  // rnd_gnt: random grant, latency not checked. hold: extra DONE cycles.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_n, input bit rnd_gnt, input int hold);
    int cyc = 1, l1 = 0, l0 = 0;
    logic [31:0] r1 = '0, r0 = '0, sa = '0, sb = '0;
    logic [31:0] prod = a * b;
    op_a = a; op_b = b; start_valid = 1'b1; gnt = 1'b1; req1_seen = 1'b0;
    tick();
    start_valid = 1'b0;
    while (!(l1 != 0 && l0 != 0) && cyc < 400) begin
      if (rv1 && l1 == 0) begin l1 = cyc; r1 = res1; end
      if (rv0 && l0 == 0) begin l0 = cyc; r0 = res0; end
      if (stall_n > 0 && cyc == stall_at) begin sa = a1; sb = b1; end
      if (stall_n > 0 && cyc > stall_at && cyc < stall_at + stall_n) begin
        chk({tag, "_stall_a"}, a1, sa);
        chk({tag, "_stall_b"}, b1, sb);
      end
      if (l1 != 0 && l0 != 0) break;
      if (rnd_gnt) gnt = ($urandom_range(0, 3) != 0);
      else gnt = !(cyc >= stall_at && cyc < stall_at + stall_n);
      tick();
      cyc++;
    end
    gnt = 1'b1;
    if (l1 == 0 || l0 == 0) begin
      chk({tag, "_timeout"}, {l1 != 0, l0 != 0}, 2'b11);
      return;
    end
    chk({tag, "_res_ee1"}, r1, prod);
    chk({tag, "_res_ee0"}, r0, prod);
    if (!rnd_gnt) begin
      chk({tag, "_lat_ee1"}, l1, exp_lat(1'b1, b) + stall_n);
      chk({tag, "_lat_ee0"}, l0, exp_lat(1'b0, b) + stall_n);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_res"}, {res1, res0}, {prod, prod});
      chk({tag, "_hold_vld"}, {rv1, rv0, sr1, sr0}, 4'b1100);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle"}, {sr1, sr0, rv1, rv0}, 4'b1100);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; start_valid = 1'b1; res_ready = 1'b0; gnt = 1'b1;
    op_a = 32'd3; op_b = 32'd5;
    tick(); tick();
    // Reset wins over start_valid; outputs at reset values.
    chk("rst_hs", {sr1, rv1, sr0, rv0}, 4'b1010);
    chk("rst_res", {res1, res0}, 64'd0);
    chk("rst_alu", {req1, a1, b1, op1}, {1'b0, 32'd0, 32'd0, ALU_ADD});
    start_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst", {sr1, rv1, req1}, 3'b100);

    run_op("3x5", 32'd3, 32'd5, 0, 0, 1'b0, 0);
    run_op("zero", 32'h12345678, 32'd0, 0, 0, 1'b0, 0);
    chk("zero_noreq", req1_seen, 1'b0);
    run_op("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0, 0);
    run_op("1x1", 32'd9, 32'd1, 0, 0, 1'b0, 0);
    run_op("7x6stall", 32'd7, 32'd6, 2, 3, 1'b0, 0);
    run_op("hold", 32'd11, 32'd13, 0, 0, 1'b0, 4);

    // Flush mid-operation, then a fresh multiply.
    op_a = 32'd3; op_b = 32'h0000FFFF; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (5) tick();
    chk("pre_flush_busy", {req1, req0}, 2'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {sr1, sr0, rv1, rv0, req1, req0}, 6'b110000);
    run_op("10x10", 32'd10, 32'd10, 0, 0, 1'b0, 0);

    for (int i = 0; i < 12; i++)
      run_op("rnd", $urandom, $urandom >> $urandom_range(0, 31), 0, 0, 1'b0, 0);
    for (int i = 0; i < 8; i++)
      run_op("rndgnt", $urandom, $urandom, 0, 0, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
